// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with prescaler, parallel load,
// wrap/saturate boundary handling, boundary pulses and sticky event flags.
// Every output is driven directly from a register.

module counter_updown_mod #(
  parameter int unsigned     WIDTH     = 8,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE  = 1'b0,
  parameter int unsigned     PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             overflow_flag,
  output logic             underflow_flag
);

  // Prescaler needs at least one bit even when every enabled cycle steps.
  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             step_s;

  // Loaded values above the terminal count are clamped to the terminal count.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if (v > MAX_V) begin
      return MAX_V;
    end else begin
      return v;
    end
  endfunction

  // Prescaler advance and step strobe; a load restarts the prescale period.
  always_comb begin
    ps_d   = ps_q;
    step_s = 1'b0;
    if (load) begin
      ps_d = '0;
    end else if (en) begin
      if (ps_q == PS_LAST) begin
        ps_d   = '0;
        step_s = 1'b1;
      end else begin
        ps_d = ps_q + PS_W'(1'b1);
      end
    end else begin
      ps_d = ps_q;
    end
  end

  // Next count and boundary pulses; boundaries are compared against the
  // terminal count explicitly since the range may not fill all WIDTH bits.
  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (load) begin
      count_d = clamp_load(load_value);
    end else if (step_s) begin
      if (up) begin
        if (count_q == MAX_V) begin
          carry_d = 1'b1;
          count_d = SATURATE ? count_q : '0;
        end else begin
          count_d = count_q + WIDTH'(1'b1);
        end
      end else begin
        if (count_q == '0) begin
          borrow_d = 1'b1;
          count_d  = SATURATE ? count_q : MAX_V;
        end else begin
          count_d = count_q - WIDTH'(1'b1);
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (carry_d) begin
      ovf_d = 1'b1;
    end else if (clear_flags) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (borrow_d) begin
      unf_d = 1'b1;
    end else if (clear_flags) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // State registers with synchronous reset overriding load and enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      ps_q     <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      ps_q     <= ps_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign count          = count_q;
  assign carry          = carry_q;
  assign borrow         = borrow_q;
  assign overflow_flag  = ovf_q;
  assign underflow_flag = unf_q;

  counter_updown_mod_chk #(
    .WIDTH (WIDTH),
    .MAX_V (MAX_V)
  ) u_chk (
    .clk    (clk),
    .rst    (rst),
    .count  (count_q),
    .carry  (carry_q),
    .borrow (borrow_q)
  );

endmodule

// Structural invariants of the counter outputs.
module counter_updown_mod_chk #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX_V = '1
) (
  input logic             clk,
  input logic             rst,
  input logic [WIDTH-1:0] count,
  input logic             carry,
  input logic             borrow
);

  a_pulses_exclusive: assert property (@(posedge clk) disable iff (rst) !(carry && borrow));
  a_count_in_range:   assert property (@(posedge clk) disable iff (rst) count <= MAX_V);

endmodule
